// File: rtl/voice_allocator.sv
// ----------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic voice allocator between a note-event source and a bank of
// NUM_VOICES envelope channels. Each accepted event is resolved by a
// one-voice-per-cycle scan followed by a single apply cycle.
//
// Note-on target priority:
//   1. same-note voice (keyed, or released but still sounding)
//   2. free voice (unkeyed and envelope idle)
//   3. oldest voice (steal)
// Note-off releases the keyed voice that holds the note, if there is one.
//
// Compile-time option:
//   VOICE_STEAL_EN  defined   : a note-on with no match and no free voice
//                               steals the oldest voice.
//                   undefined : that note-on is discarded and ev_dropped
//                               pulses for one cycle.
//
// Ports:
//   CLK, RESET   clock, synchronous active-high reset
//   ev_valid     in   event present
//   ev_ready     out  allocator can accept an event
//   ev_on        in   1 = note-on, 0 = note-off
//   ev_note      in   note number of the event
//   env_idle     in   per voice: envelope is in its reset/done state
//   voice_key    out  per-voice key-in
//   voice_rst    out  per-voice one-cycle envelope reset pulse
//   voice_note   out  per-voice note, voice i at [i*NOTE_W +: NOTE_W]
//   ev_dropped   out  one-cycle pulse when a note-on is discarded
//   dbg_state    out  current FSM state (0 IDLE, 1 SCAN, 2 APPLY)
//
// Handshake: an event transfers on a rising edge where ev_valid && ev_ready.
// ev_ready is high only in IDLE and never while RESET is high; the source
// holds ev_on/ev_note stable while ev_valid is high and not yet accepted.
// ----------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int AGE_W      = 8
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NUM_VOICES-1:0]        env_idle,
    output logic [NUM_VOICES-1:0]        voice_key,
    output logic [NUM_VOICES-1:0]        voice_rst,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic                         ev_dropped,
    output logic [1:0]                   dbg_state
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_LAST = idx_t'(NUM_VOICES - 1);

    state_e              state_q, state_d;
    logic                on_q, on_d;
    logic [NOTE_W-1:0]   ev_note_q, ev_note_d;
    idx_t                idx_q, idx_d;

    // Scan candidates
    logic                match_vld_q, match_vld_d;
    idx_t                match_idx_q, match_idx_d;
    logic                free_vld_q, free_vld_d;
    idx_t                free_idx_q, free_idx_d;
`ifdef VOICE_STEAL_EN
    idx_t                old_idx_q, old_idx_d;
    logic [AGE_W-1:0]    old_age_q, old_age_d;
`endif

    // Per-voice state
    logic [NUM_VOICES-1:0] key_q, key_d;
    logic [NUM_VOICES-1:0] rst_q, rst_d;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_d  [NUM_VOICES];
    logic                  drop_q, drop_d;

    // Voice under examination during SCAN
    logic              sel_key;
    logic              sel_idle;
    logic [NOTE_W-1:0] sel_note;
    logic              scan_match;
    logic              scan_free;

    assign sel_key  = key_q[idx_q];
    assign sel_idle = env_idle[idx_q];
    assign sel_note = note_q[idx_q];

    // A note-off may only release a keyed voice, so a released-but-sounding
    // voice counts as a match for note-on only.
    assign scan_match = (sel_note == ev_note_q) && (sel_key || (on_q && !sel_idle));
    assign scan_free  = !sel_key && sel_idle;

    // Note-on target selection from the scan results
    logic tgt_vld;
    idx_t tgt_idx;
    logic drop_now;

    always_comb begin
        tgt_vld  = 1'b0;
        tgt_idx  = '0;
        drop_now = 1'b0;
        if (match_vld_q) begin
            tgt_vld = 1'b1;
            tgt_idx = match_idx_q;
        end else if (free_vld_q) begin
            tgt_vld = 1'b1;
            tgt_idx = free_idx_q;
        end else begin
`ifdef VOICE_STEAL_EN
            tgt_vld = 1'b1;
            tgt_idx = old_idx_q;
`else
            drop_now = 1'b1;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        on_d        = on_q;
        ev_note_d   = ev_note_q;
        idx_d       = idx_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
`ifdef VOICE_STEAL_EN
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
`endif
        key_d       = key_q;
        rst_d       = '0;
        note_d      = note_q;
        age_d       = age_q;
        drop_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ev_valid) begin
                    on_d        = ev_on;
                    ev_note_d   = ev_note;
                    idx_d       = '0;
                    match_vld_d = 1'b0;
                    match_idx_d = '0;
                    free_vld_d  = 1'b0;
                    free_idx_d  = '0;
`ifdef VOICE_STEAL_EN
                    old_idx_d   = '0;
                    old_age_d   = '0;
`endif
                    state_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (scan_match && !match_vld_q) begin
                    match_vld_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (scan_free && !free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
`ifdef VOICE_STEAL_EN
                // Strictly greater keeps the lowest index on ties.
                if (age_q[idx_q] > old_age_q) begin
                    old_idx_d = idx_q;
                    old_age_d = age_q[idx_q];
                end
`endif
                if (idx_q == IDX_LAST) begin
                    state_d = ST_APPLY;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_APPLY: begin
                state_d = ST_IDLE;
                if (on_q) begin
                    drop_d = drop_now;
                    if (tgt_vld) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (idx_t'(i) == tgt_idx) begin
                                key_d[i]  = 1'b1;
                                rst_d[i]  = 1'b1;
                                note_d[i] = ev_note_q;
                                age_d[i]  = '0;
                            end else if (age_q[i] != '1) begin
                                age_d[i] = age_q[i] + 1'b1;
                            end
                        end
                    end
                end else if (match_vld_q) begin
                    key_d[match_idx_q] = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            on_q        <= 1'b0;
            ev_note_q   <= '0;
            idx_q       <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
`ifdef VOICE_STEAL_EN
            old_idx_q   <= '0;
            old_age_q   <= '0;
`endif
            key_q       <= '0;
            rst_q       <= '0;
            drop_q      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            on_q        <= on_d;
            ev_note_q   <= ev_note_d;
            idx_q       <= idx_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
`ifdef VOICE_STEAL_EN
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
`endif
            key_q       <= key_d;
            rst_q       <= rst_d;
            drop_q      <= drop_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= note_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    assign ev_ready   = (state_q == ST_IDLE) && !RESET;
    assign voice_key  = key_q;
    assign voice_rst  = rst_q;
    assign ev_dropped = drop_q;
    assign dbg_state  = state_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
        assign voice_note[g*NOTE_W +: NOTE_W] = note_q[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    localparam int NV  = 4;
    localparam int NW  = 7;
    localparam int AW  = 8;
    localparam int SBW = 2*NV + NV*NW + 1;
    localparam int AGE_MAX = (1 << AW) - 1;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic             CLK = 1'b0;
    logic             RESET;
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_on;
    logic [NW-1:0]    ev_note;
    logic [NV-1:0]    env_idle;
    logic [NV-1:0]    voice_key;
    logic [NV-1:0]    voice_rst;
    logic [NV*NW-1:0] voice_note;
    logic             ev_dropped;
    logic [1:0]       dbg_state;

    always #5 CLK = ~CLK;

    voice_allocator #(
        .NUM_VOICES (NV),
        .NOTE_W     (NW),
        .AGE_W      (AW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_note    (ev_note),
        .env_idle   (env_idle),
        .voice_key  (voice_key),
        .voice_rst  (voice_rst),
        .voice_note (voice_note),
        .ev_dropped (ev_dropped),
        .dbg_state  (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: voice table plus expected-output queue
    // ------------------------------------------------------------------
    bit              m_key  [NV];
    int              m_note [NV];
    int              m_age  [NV];
    logic [SBW-1:0]  exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_key[i]  = 1'b0;
            m_note[i] = 0;
            m_age[i]  = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_event(input bit on, input int note, input logic [NV-1:0] idle);
        int             tgt;
        bit             drop;
        logic [NV-1:0]  ek, er;
        logic [NV*NW-1:0] en;
        tgt  = -1;
        drop = 1'b0;
        er   = '0;
        if (on) begin
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && m_note[i] == note && (m_key[i] || !idle[i])) tgt = i;
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && !m_key[i] && idle[i]) tgt = i;
            if (tgt < 0) begin
`ifdef VOICE_STEAL_EN
                tgt = 0;
                for (int i = 1; i < NV; i++)
                    if (m_age[i] > m_age[tgt]) tgt = i;
`else
                drop = 1'b1;
`endif
            end
            if (tgt >= 0) begin
                for (int i = 0; i < NV; i++) begin
                    if (i == tgt) begin
                        m_key[i]  = 1'b1;
                        m_note[i] = note;
                        m_age[i]  = 0;
                    end else if (m_age[i] < AGE_MAX) begin
                        m_age[i] = m_age[i] + 1;
                    end
                end
                er[tgt] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NV; i++)
                if (m_key[i] && m_note[i] == note) m_key[i] = 1'b0;
        end
        for (int i = 0; i < NV; i++) begin
            ek[i] = m_key[i];
            en[i*NW +: NW] = NW'(m_note[i]);
        end
        exp_q.push_back({ek, er, en, drop});
    endtask

    // ------------------------------------------------------------------
    // Driver: one event through the handshake, then check the result
    // ------------------------------------------------------------------
    task automatic send_event(input bit on, input int note);
        int               cyc;
        logic [NV-1:0]    ek, er;
        logic [NV*NW-1:0] en;
        logic             ed;
        @(negedge CLK);
        cyc = 0;
        while (ev_ready !== 1'b1 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_event: got %b expected 1", ev_ready);
        end
        model_event(on, note, env_idle);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = NW'(note);
        @(negedge CLK);
        ev_valid = 1'b0;
        checks++;
        if (ev_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_accept: got %b expected 0", ev_ready);
        end
        cyc = 0;
        while (ev_ready !== 1'b1 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (cyc != NV + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc, NV + 1);
        end
        {ek, er, en, ed} = exp_q.pop_front();
        checks++;
        if (voice_key !== ek) begin
            errors++;
            $display("FAIL voice_key (on=%0d note=%0d): got %b expected %b", on, note, voice_key, ek);
        end
        checks++;
        if (voice_rst !== er) begin
            errors++;
            $display("FAIL voice_rst (on=%0d note=%0d): got %b expected %b", on, note, voice_rst, er);
        end
        checks++;
        if (voice_note !== en) begin
            errors++;
            $display("FAIL voice_note (on=%0d note=%0d): got %h expected %h", on, note, voice_note, en);
        end
        checks++;
        if (ev_dropped !== ed) begin
            errors++;
            $display("FAIL ev_dropped (on=%0d note=%0d): got %b expected %b", on, note, ev_dropped, ed);
        end
        @(negedge CLK);
        checks++;
        if (voice_rst !== '0 || ev_dropped !== 1'b0) begin
            errors++;
            $display("FAIL pulse_clear: got rst=%b drop=%b expected 0/0", voice_rst, ev_dropped);
        end
        checks++;
        if (voice_key !== ek) begin
            errors++;
            $display("FAIL key_hold: got %b expected %b", voice_key, ek);
        end
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        ev_valid = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        env_idle = '1;
        RESET    = 1'b1;
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd33;
        repeat (3) @(negedge CLK);
        checks++;
        if (ev_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", ev_ready);
        end
        checks++;
        if (voice_key !== '0 || voice_rst !== '0 || voice_note !== '0 || ev_dropped !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got key=%b rst=%b note=%h drop=%b expected all 0",
                     voice_key, voice_rst, voice_note, ev_dropped);
        end
        ev_valid = 1'b0;
        RESET    = 1'b0;
        model_reset();
        @(negedge CLK);
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", ev_ready);
        end
    endtask

    task automatic test_basic_note_on();
        send_event(1'b1, 60);
        checks++;
        if (voice_key !== 4'b0001 || voice_note[0 +: NW] !== 7'd60) begin
            errors++;
            $display("FAIL basic_on: got key=%b note0=%0d expected 0001/60", voice_key, voice_note[0 +: NW]);
        end
    endtask

    task automatic test_fill_voices();
        send_event(1'b1, 62);
        send_event(1'b1, 64);
        send_event(1'b1, 65);
        checks++;
        if (voice_key !== 4'b1111 || voice_note !== {7'd65, 7'd64, 7'd62, 7'd60}) begin
            errors++;
            $display("FAIL fill: got key=%b notes=%h expected 1111 with 65,64,62,60", voice_key, voice_note);
        end
    endtask

    task automatic test_steal_or_drop();
        // ages are 3,2,1,0 so voice 0 is the steal victim
        send_event(1'b1, 67);
    endtask

    task automatic test_note_off();
        send_event(1'b0, 62);
        checks++;
        if (voice_key !== 4'b1101 || voice_note[NW +: NW] !== 7'd62) begin
            errors++;
            $display("FAIL note_off: got key=%b note1=%0d expected 1101/62", voice_key, voice_note[NW +: NW]);
        end
        send_event(1'b0, 70);
    endtask

    task automatic test_retrigger();
        do_reset();
        env_idle = '1;
        send_event(1'b1, 60);
        send_event(1'b1, 62);
        send_event(1'b1, 64);
        send_event(1'b0, 64);
        env_idle = 4'b1011;
        send_event(1'b1, 64);
        checks++;
        if (voice_key !== 4'b0111 || voice_note[3*NW +: NW] !== 7'd0) begin
            errors++;
            $display("FAIL retrigger: got key=%b note3=%0d expected 0111/0", voice_key, voice_note[3*NW +: NW]);
        end
        env_idle = '1;
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        env_idle = '1;
        send_event(1'b1, 50);
        @(negedge CLK);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd61;
        @(negedge CLK);            // accepted at E0
        ev_valid = 1'b0;
        @(negedge CLK);            // past E1
        RESET = 1'b1;
        @(negedge CLK);            // reset sampled at E2
        checks++;
        if (ev_ready !== 1'b0 || voice_key !== '0 || voice_rst !== '0 || voice_note !== '0) begin
            errors++;
            $display("FAIL mid_scan_reset: got ready=%b key=%b rst=%b note=%h expected all 0",
                     ev_ready, voice_key, voice_rst, voice_note);
        end
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_scan_ready: got %b expected 1", ev_ready);
        end
        repeat (NV + 3) @(negedge CLK);
        checks++;
        if (voice_key !== '0 || voice_rst !== '0 || ev_dropped !== 1'b0) begin
            errors++;
            $display("FAIL event_lost: got key=%b rst=%b drop=%b expected 0", voice_key, voice_rst, ev_dropped);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 200; n++) begin
            env_idle = NV'($urandom);
            send_event($urandom_range(0, 4) > 1, 60 + $urandom_range(0, 6));
        end
        env_idle = '1;
    endtask

    initial begin
        RESET    = 1'b1;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        env_idle = '1;
        model_reset();
        test_reset();
        test_basic_note_on();
        test_fill_voices();
        test_steal_or_drop();
        test_note_off();
        test_retrigger();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
